// File: rtl/duck_motion_ctrl.sv
// Per-frame erase / step / redraw sequencer for one duck sprite.
// Optional falling-duck behaviour is enabled by defining DUCK_FALL_EN.
module duck_motion_ctrl #(
    parameter int X_MAX   = 152,
    parameter int Y_MAX   = 112,
    parameter int X_START = 0,
    parameter int Y_START = 56,
    parameter int STEP    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       draw_ready,
    output logic       draw_req,
    output logic       draw_erase,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic       dir_x,
    output logic       dir_y,
    output logic       fallen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_MOVE,
        S_DRAW
`ifdef DUCK_FALL_EN
        , S_DONE
`endif
    } state_t;

    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [8:0] XMAX9 = 9'(X_MAX);
    localparam logic [8:0] YMAX9 = 9'(Y_MAX);
    localparam logic [7:0] X0    = 8'(X_START);
    localparam logic [6:0] Y0    = 7'(Y_START);

    state_t     state, state_n;
    logic       tick_prev;
    logic       pending, pending_n;
    logic       frame, accept, falling;
    logic [7:0] x, x_n, x_out_n;
    logic [6:0] y, y_n, y_out_n;
    logic       dir_x_n, dir_y_n;
    logic       req_n, erase_n;

    logic [8:0] x9, y9, nx9, ny9, fy9;
    logic [7:0] step_x;
    logic [6:0] step_y, fall_y;
    logic       step_dx, step_dy;

    assign frame  = frame_tick & ~tick_prev;
    assign accept = draw_req & draw_ready;
    assign x9     = {1'b0, x};
    assign y9     = {2'b00, y};
    assign fy9    = y9 + (STEP9 << 1);
    assign fall_y = (fy9 >= YMAX9) ? YMAX9[6:0] : fy9[6:0];

    // Bounce: clamp to the wall and reverse instead of wrapping.
    always_comb begin
        nx9     = dir_x ? x9 + STEP9 : x9 - STEP9;
        ny9     = dir_y ? y9 + STEP9 : y9 - STEP9;
        step_x  = nx9[7:0];
        step_dx = dir_x;
        step_y  = ny9[6:0];
        step_dy = dir_y;
        if (dir_x && nx9 >= XMAX9) begin
            step_x  = XMAX9[7:0];
            step_dx = 1'b0;
        end else if (!dir_x && x9 < STEP9) begin
            step_x  = '0;
            step_dx = 1'b1;
        end
        if (dir_y && ny9 >= YMAX9) begin
            step_y  = YMAX9[6:0];
            step_dy = 1'b0;
        end else if (!dir_y && y9 < STEP9) begin
            step_y  = '0;
            step_dy = 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        x_n       = x;
        y_n       = y;
        dir_x_n   = dir_x;
        dir_y_n   = dir_y;
        req_n     = draw_req;
        erase_n   = draw_erase;
        x_out_n   = x_out;
        y_out_n   = y_out;
        unique case (state)
            S_IDLE: begin
                if (pending || frame) begin
                    state_n   = S_ERASE;
                    req_n     = 1'b1;
                    erase_n   = 1'b1;
                    x_out_n   = x;
                    y_out_n   = y;
                    pending_n = pending & frame;
                end
            end
            S_ERASE: begin
                if (frame) pending_n = 1'b1;
                if (accept) begin
                    state_n = S_MOVE;
                    req_n   = 1'b0;
                end
            end
            S_MOVE: begin
                if (frame) pending_n = 1'b1;
                if (falling) begin
                    y_n = fall_y;
                end else begin
                    x_n     = step_x;
                    y_n     = step_y;
                    dir_x_n = step_dx;
                    dir_y_n = step_dy;
                end
                state_n = S_DRAW;
                req_n   = 1'b1;
                erase_n = 1'b0;
                x_out_n = falling ? x : step_x;
                y_out_n = falling ? fall_y : step_y;
            end
            S_DRAW: begin
                if (frame) pending_n = 1'b1;
                if (accept) begin
                    state_n = S_IDLE;
                    req_n   = 1'b0;
`ifdef DUCK_FALL_EN
                    if (falling && y == YMAX9[6:0]) state_n = S_DONE;
`endif
                end
            end
`ifdef DUCK_FALL_EN
            S_DONE: begin
                pending_n = 1'b0;
            end
`endif
            default: begin
                state_n = S_IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            tick_prev  <= 1'b0;
            pending    <= 1'b0;
            x          <= X0;
            y          <= Y0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b0;
            draw_req   <= 1'b0;
            draw_erase <= 1'b0;
            x_out      <= X0;
            y_out      <= Y0;
        end else begin
            state      <= state_n;
            tick_prev  <= frame_tick;
            pending    <= pending_n;
            x          <= x_n;
            y          <= y_n;
            dir_x      <= dir_x_n;
            dir_y      <= dir_y_n;
            draw_req   <= req_n;
            draw_erase <= erase_n;
            x_out      <= x_out_n;
            y_out      <= y_out_n;
        end
    end

`ifdef DUCK_FALL_EN
    logic hit_latched;

    assign falling = hit_latched;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_latched <= 1'b0;
            fallen      <= 1'b0;
        end else begin
            if (hit) hit_latched <= 1'b1;
            if (state_n == S_DONE) fallen <= 1'b1;
        end
    end
`else
    logic unused_hit;

    assign unused_hit = hit;
    assign falling    = 1'b0;
    assign fallen     = 1'b0;
`endif

endmodule

// File: tb/tb_duck_motion_ctrl.sv
// Randomised frame/stall bench for duck_motion_ctrl with a bounce model.
// Fall checks run only when DUCK_FALL_EN is defined.
module tb_duck_motion_ctrl;

    localparam int X_MAX   = 152;
    localparam int Y_MAX   = 112;
    localparam int X_START = 0;
    localparam int Y_START = 56;
    localparam int STEP    = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       hit;
    logic       draw_ready;
    logic       draw_req;
    logic       draw_erase;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic       dir_x;
    logic       dir_y;
    logic       fallen;

    int checks   = 0;
    int failures = 0;

    int mx, my;
    bit mdx, mdy;
    bit m_fall, m_done;

    duck_motion_ctrl #(
        .X_MAX  (X_MAX),
        .Y_MAX  (Y_MAX),
        .X_START(X_START),
        .Y_START(Y_START),
        .STEP   (STEP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .frame_tick(frame_tick),
        .hit       (hit),
        .draw_ready(draw_ready),
        .draw_req  (draw_req),
        .draw_erase(draw_erase),
        .x_out     (x_out),
        .y_out     (y_out),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .fallen    (fallen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = X_START;
        my = Y_START;
        mdx = 1'b1;
        mdy = 1'b0;
        m_fall = 1'b0;
        m_done = 1'b0;
    endtask

    // One frame's move, straight from the bounce / fall rules.
    task automatic model_step();
        if (m_fall) begin
            my = (my + 2 * STEP > Y_MAX) ? Y_MAX : my + 2 * STEP;
            if (my == Y_MAX) m_done = 1'b1;
        end else begin
            if (mdx) begin
                if (mx + STEP >= X_MAX) begin mx = X_MAX; mdx = 1'b0; end
                else mx = mx + STEP;
            end else begin
                if (mx < STEP) begin mx = 0; mdx = 1'b1; end
                else mx = mx - STEP;
            end
            if (mdy) begin
                if (my + STEP >= Y_MAX) begin my = Y_MAX; mdy = 1'b0; end
                else my = my + STEP;
            end else begin
                if (my < STEP) begin my = 0; mdy = 1'b1; end
                else my = my - STEP;
            end
        end
    endtask

    task automatic chk_req(input string tag, input bit er);
        chk({tag, "_req"}, 32'(draw_req), 32'd1);
        chk({tag, "_erase"}, 32'(draw_erase), 32'(er));
        chk({tag, "_x"}, 32'(x_out), 32'(mx));
        chk({tag, "_y"}, 32'(y_out), 32'(my));
        chk({tag, "_dx"}, 32'(dir_x), 32'(mdx));
        chk({tag, "_dy"}, 32'(dir_y), 32'(mdy));
    endtask

    // Called at a negedge with the DUT idle (or with a pending frame).
    task automatic run_frame(input bit raise, input int se, input int sd,
                             input bit extra);
        if (raise) frame_tick = 1'b1;
        draw_ready = (se == 0);
        @(negedge clk);
        frame_tick = 1'b0;
        chk_req("erase", 1'b1);
        for (int i = 0; i < se; i++) begin
            if (extra && i < 4) frame_tick = (i == 0 || i == 2);
            @(negedge clk);
            chk_req("erase_hold", 1'b1);
        end
        frame_tick = 1'b0;
        draw_ready = 1'b1;
        @(negedge clk);
        chk("move_req", 32'(draw_req), 32'd0);
        model_step();
        draw_ready = (sd == 0);
        @(negedge clk);
        chk_req("draw", 1'b0);
        for (int i = 0; i < sd; i++) begin
            @(negedge clk);
            chk_req("draw_hold", 1'b0);
        end
        draw_ready = 1'b1;
        @(negedge clk);
        chk("idle_req", 32'(draw_req), 32'd0);
        chk("fallen", 32'(fallen), 32'(m_done));
        draw_ready = 1'b0;
    endtask

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            draw_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk(tag, 32'(draw_req), 32'd0);
        end
        draw_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        frame_tick = 1'b0;
        draw_ready = 1'b0;
        hit = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        chk("rst_req", 32'(draw_req), 32'd0);
        chk("rst_erase", 32'(draw_erase), 32'd0);
        chk("rst_x", 32'(x_out), 32'(X_START));
        chk("rst_y", 32'(y_out), 32'(Y_START));
        chk("rst_dx", 32'(dir_x), 32'd1);
        chk("rst_dy", 32'(dir_y), 32'd0);
        chk("rst_fallen", 32'(fallen), 32'd0);

        // First frame with ready high: fixed 4-cycle cost
        run_frame(1'b1, 0, 0, 1'b0);
        chk("first_x", 32'(x_out), 32'd1);
        chk("first_y", 32'(y_out), 32'd55);

        // Long erase stall with two extra edges: one pending frame only
        run_frame(1'b1, 10, 0, 1'b1);
        run_frame(1'b0, 0, 2, 1'b0);
        quiet(10, "no_extra_frame");

        // Random frames cover both x and y wall bounces
        for (int f = 0; f < 200; f++) begin
            run_frame(1'b1, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b0);
            quiet(int'($urandom_range(0, 3)), "gap_req");
        end
        chk("x_bounced", 32'(mdx), 32'd0);

        // Async reset while a draw request is stalled
        frame_tick = 1'b1;
        draw_ready = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        draw_ready = 1'b1;
        @(negedge clk);
        draw_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_draw", 32'(draw_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(draw_req), 32'd0);
        chk("mid_rst_x", 32'(x_out), 32'(X_START));
        chk("mid_rst_y", 32'(y_out), 32'(Y_START));
        chk("mid_rst_dx", 32'(dir_x), 32'd1);
        chk("mid_rst_dy", 32'(dir_y), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        run_frame(1'b1, 1, 1, 1'b0);

`ifdef DUCK_FALL_EN
        do_reset();
        for (int k = 0; k < 400 && !(my == 100 && mdy); k++)
            run_frame(1'b1, 0, 0, 1'b0);
        chk("reach_y100", 32'(my), 32'd100);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        m_fall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("not_fallen_yet", 32'(fallen), 32'd0);
            run_frame(1'b1, int'($urandom_range(0, 2)), 0, 1'b0);
        end
        chk("fall_y", 32'(y_out), 32'(Y_MAX));
        chk("fallen_set", 32'(fallen), 32'd1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        quiet(8, "done_no_req");
        chk("fallen_hold", 32'(fallen), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
